// File: rtl/pmem_arbiter.sv
// rtl/pmem_arbiter.sv - round-robin arbiter sharing one physical memory port among I-cache, D-cache and victim cache
module pmem_arbiter #(
    parameter int width = 256
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             icache_read,
    input  logic [31:0]      icache_address,
    output logic [width-1:0] icache_rdata,
    output logic             icache_resp,

    input  logic             dcache_read,
    input  logic             dcache_write,
    input  logic [31:0]      dcache_address,
    input  logic [width-1:0] dcache_wdata,
    output logic [width-1:0] dcache_rdata,
    output logic             dcache_resp,

    input  logic             vc_write,
    input  logic [31:0]      vc_address,
    input  logic [width-1:0] vc_wdata,
    output logic             vc_resp,

    output logic             pmem_read,
    output logic             pmem_write,
    output logic [31:0]      pmem_address,
    output logic [width-1:0] pmem_wdata,
    input  logic [width-1:0] pmem_rdata,
    input  logic             pmem_resp
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam logic [1:0]  ID_IC     = 2'd0;
    localparam logic [1:0]  ID_DC     = 2'd1;
    localparam logic [1:0]  ID_VC     = 2'd2;
    localparam logic [31:0] LINE_MASK = 32'hFFFF_FFE0;

    state_t             state_q, state_d;
    logic [1:0]         last_grant_q, last_grant_d;
    logic [1:0]         id_q, id_d;
    logic               wr_q, wr_d;
    logic [31:0]        addr_q, addr_d;
    logic [width-1:0]   wdata_q, wdata_d;

    logic [3:0]         pend;
    logic [1:0]         ord0, ord1, ord2;
    logic [1:0]         win_id, grant_id;
    logic               win_valid, win_is_read, hazard;
    logic [31:0]        win_addr;
    logic               active, done;

    // Round-robin pick starting after last_grant, with a write-back override when a read would hit a dirty victim line
    always_comb begin
        pend = {1'b0, vc_write, dcache_read | dcache_write, icache_read};
        case (last_grant_q)
            ID_DC: begin
                ord0 = ID_VC;
                ord1 = ID_IC;
                ord2 = ID_DC;
            end
            ID_VC: begin
                ord0 = ID_IC;
                ord1 = ID_DC;
                ord2 = ID_VC;
            end
            default: begin
                ord0 = ID_DC;
                ord1 = ID_VC;
                ord2 = ID_IC;
            end
        endcase
        win_valid = |pend[2:0];
        win_id    = ord2;
        if (pend[ord1]) win_id = ord1;
        if (pend[ord0]) win_id = ord0;
        case (win_id)
            ID_IC:   win_addr = icache_address;
            ID_DC:   win_addr = dcache_address;
            default: win_addr = vc_address;
        endcase
        win_is_read = (win_id == ID_IC) || ((win_id == ID_DC) && !dcache_write);
        hazard      = win_valid && win_is_read && vc_write &&
                      (vc_address[31:5] == win_addr[31:5]);
        grant_id    = hazard ? ID_VC : win_id;
    end

    // Next-state, transaction latch and output decode; everything is silenced while rst is high
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        id_d         = id_q;
        wr_d         = wr_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        case (state_q)
            IDLE: begin
                if (win_valid) begin
                    state_d      = BUSY;
                    last_grant_d = grant_id;
                    id_d         = grant_id;
                    case (grant_id)
                        ID_IC: begin
                            wr_d    = 1'b0;
                            addr_d  = icache_address & LINE_MASK;
                            wdata_d = '0;
                        end
                        ID_DC: begin
                            wr_d    = dcache_write;
                            addr_d  = dcache_address & LINE_MASK;
                            wdata_d = dcache_wdata;
                        end
                        default: begin
                            wr_d    = 1'b1;
                            addr_d  = vc_address & LINE_MASK;
                            wdata_d = vc_wdata;
                        end
                    endcase
                end
            end
            BUSY: begin
                if (pmem_resp) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        active       = (state_q == BUSY) && !rst;
        done         = active && pmem_resp;
        pmem_read    = active && !wr_q;
        pmem_write   = active && wr_q;
        pmem_address = active ? addr_q : 32'd0;
        pmem_wdata   = (active && wr_q) ? wdata_q : '0;
        icache_resp  = done && (id_q == ID_IC);
        dcache_resp  = done && (id_q == ID_DC);
        vc_resp      = done && (id_q == ID_VC);
        icache_rdata = (icache_resp && !wr_q) ? pmem_rdata : '0;
        dcache_rdata = (dcache_resp && !wr_q) ? pmem_rdata : '0;
    end

    // State and latched-transaction registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= ID_IC;
            id_q         <= ID_IC;
            wr_q         <= 1'b0;
            addr_q       <= 32'd0;
            wdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            id_q         <= id_d;
            wr_q         <= wr_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
        end
    end

endmodule

// File: tb/tb_pmem_arbiter.sv
// tb/tb_pmem_arbiter.sv - directed scoreboard bench for pmem_arbiter
module tb_pmem_arbiter;

    localparam logic [1:0] ID_IC = 2'd0;
    localparam logic [1:0] ID_DC = 2'd1;
    localparam logic [1:0] ID_VC = 2'd2;

    typedef struct {
        logic [1:0]   id;
        logic         wr;
        logic [31:0]  addr;
        logic [255:0] data;
    } txn_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         icache_read;
    logic [31:0]  icache_address;
    logic [255:0] icache_rdata;
    logic         icache_resp;
    logic         dcache_read;
    logic         dcache_write;
    logic [31:0]  dcache_address;
    logic [255:0] dcache_wdata;
    logic [255:0] dcache_rdata;
    logic         dcache_resp;
    logic         vc_write;
    logic [31:0]  vc_address;
    logic [255:0] vc_wdata;
    logic         vc_resp;
    logic         pmem_read;
    logic         pmem_write;
    logic [31:0]  pmem_address;
    logic [255:0] pmem_wdata;
    logic [255:0] pmem_rdata;
    logic         pmem_resp;

    int   errors = 0;
    int   checks = 0;
    txn_t sb[$];

    pmem_arbiter #(.width(256)) dut (
        .clk(clk), .rst(rst),
        .icache_read(icache_read), .icache_address(icache_address),
        .icache_rdata(icache_rdata), .icache_resp(icache_resp),
        .dcache_read(dcache_read), .dcache_write(dcache_write),
        .dcache_address(dcache_address), .dcache_wdata(dcache_wdata),
        .dcache_rdata(dcache_rdata), .dcache_resp(dcache_resp),
        .vc_write(vc_write), .vc_address(vc_address), .vc_wdata(vc_wdata),
        .vc_resp(vc_resp),
        .pmem_read(pmem_read), .pmem_write(pmem_write),
        .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
        .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_pmem_read"}, pmem_read, 1'b0);
        check({tag, "_pmem_write"}, pmem_write, 1'b0);
        check({tag, "_pmem_address"}, pmem_address, 32'd0);
        check({tag, "_pmem_wdata"}, pmem_wdata, 256'd0);
        check({tag, "_resps"}, {icache_resp, dcache_resp, vc_resp}, 3'b000);
        check({tag, "_rdatas"}, icache_rdata | dcache_rdata, 256'd0);
    endtask

    task automatic check_resp(input string tag, input logic [1:0] id, input logic [255:0] rd);
        check({tag, "_icache_resp"}, icache_resp, id == ID_IC);
        check({tag, "_dcache_resp"}, dcache_resp, id == ID_DC);
        check({tag, "_vc_resp"}, vc_resp, id == ID_VC);
        check({tag, "_icache_rdata"}, icache_rdata, (id == ID_IC) ? rd : 256'd0);
        check({tag, "_dcache_rdata"}, dcache_rdata, (id == ID_DC) ? rd : 256'd0);
    endtask

    task automatic drop(input logic [1:0] id);
        case (id)
            ID_IC: icache_read = 1'b0;
            ID_DC: begin
                dcache_read  = 1'b0;
                dcache_write = 1'b0;
            end
            default: vc_write = 1'b0;
        endcase
    endtask

    task automatic push(input logic [1:0] id, input logic wr, input logic [31:0] addr, input logic [255:0] data);
        txn_t t;
        t.id = id; t.wr = wr; t.addr = addr; t.data = data;
        sb.push_back(t);
    endtask

    // Memory responder: waits for a strobe, compares it to the scoreboard head, answers and checks the resp
    task automatic serve(input string tag, input logic [255:0] rd);
        txn_t t;
        int   waited = 0;
        do begin
            step();
            waited++;
        end while (!(pmem_read || pmem_write) && waited < 20);
        check({tag, "_strobe_seen"}, pmem_read | pmem_write, 1'b1);
        check({tag, "_latency"}, waited, 1);
        check({tag, "_sb_nonempty"}, sb.size() != 0, 1'b1);
        if (sb.size() == 0) return;
        t = sb.pop_front();
        check({tag, "_pmem_write"}, pmem_write, t.wr);
        check({tag, "_pmem_read"}, pmem_read, !t.wr);
        check({tag, "_pmem_address"}, pmem_address, t.addr);
        check({tag, "_pmem_wdata"}, pmem_wdata, t.wr ? t.data : 256'd0);
        pmem_rdata = rd;
        pmem_resp  = 1'b1;
        #1;
        check_resp(tag, t.id, t.wr ? 256'd0 : rd);
        step();
        pmem_resp  = 1'b0;
        pmem_rdata = '0;
        drop(t.id);
    endtask

    task automatic do_reset();
        icache_read = 0; icache_address = 0;
        dcache_read = 0; dcache_write = 0; dcache_address = 0; dcache_wdata = 0;
        vc_write = 0; vc_address = 0; vc_wdata = 0;
        pmem_rdata = 0; pmem_resp = 0;
        rst = 1'b1;
        step();
        check_idle_outputs("reset");
        step();
        rst = 1'b0;
    endtask

    initial begin
        logic [255:0] d0, d1, d2;
        d0 = {8{$urandom()}};
        d1 = {8{$urandom()}};
        d2 = {8{$urandom()}};

        // Single I-cache fill, address aligned, latched address immune to input changes
        do_reset();
        icache_read = 1'b1; icache_address = 32'h0000_1234;
        push(ID_IC, 1'b0, 32'h0000_1220, '0);
        step();
        check("ic_latency1_read", pmem_read, 1'b1);
        icache_address = 32'hABCD_0000;
        #1;
        check("ic_latched_addr", pmem_address, 32'h0000_1220);
        icache_address = 32'h0000_1234;
        sb.delete();
        rst = 1'b1; step(); rst = 1'b0; icache_read = 1'b0;
        check_idle_outputs("post_abort");
        icache_read = 1'b1;
        push(ID_IC, 1'b0, 32'h0000_1220, '0);
        serve("ic_fill", d0);

        // All three pending after reset: dcache, vc, icache
        do_reset();
        icache_read = 1; icache_address = 32'h0000_1000;
        dcache_write = 1; dcache_address = 32'h0000_2004; dcache_wdata = d1;
        vc_write = 1; vc_address = 32'h0000_3008; vc_wdata = d2;
        push(ID_DC, 1'b1, 32'h0000_2000, d1);
        push(ID_VC, 1'b1, 32'h0000_3000, d2);
        push(ID_IC, 1'b0, 32'h0000_1000, '0);
        serve("rr1_dc", d0);
        serve("rr1_vc", d0);
        serve("rr1_ic", d1);

        // Rotation continues; a re-raised dcache request waits its turn
        icache_read = 1;
        dcache_read = 1; dcache_write = 1; dcache_wdata = d0;
        vc_write = 1;
        push(ID_DC, 1'b1, 32'h0000_2000, d0);
        push(ID_VC, 1'b1, 32'h0000_3000, d2);
        push(ID_IC, 1'b0, 32'h0000_1000, '0);
        serve("rr2_dc", d1);
        dcache_read = 1; dcache_address = 32'h0000_4010;
        push(ID_DC, 1'b0, 32'h0000_4000, '0);
        serve("rr2_vc", d1);
        serve("rr2_ic", d2);
        serve("rr2_dcrd", d0);

        // Read hitting the victim line: write-back goes first
        do_reset();
        dcache_read = 1; dcache_address = 32'h0000_0040;
        vc_write = 1; vc_address = 32'h0000_005F; vc_wdata = d1;
        push(ID_VC, 1'b1, 32'h0000_0040, d1);
        push(ID_DC, 1'b0, 32'h0000_0040, '0);
        serve("haz_vc", d2);
        serve("haz_dc", d2);

        // Reset while BUSY coincident with pmem_resp: aborted, no resp
        icache_read = 1; icache_address = 32'h0000_0080;
        step();
        check("abort_busy", pmem_read, 1'b1);
        pmem_resp = 1; pmem_rdata = d0; rst = 1;
        #1;
        check_idle_outputs("abort_rst");
        step();
        rst = 0; pmem_resp = 0; pmem_rdata = 0; icache_read = 0;
        #1;
        check_idle_outputs("abort_after");
        step();
        check_idle_outputs("abort_idle");

        // pmem_resp in IDLE is ignored
        pmem_resp = 1; pmem_rdata = d1;
        #1;
        check_idle_outputs("idle_resp");
        step();
        pmem_resp = 0; pmem_rdata = 0;
        check_idle_outputs("idle_resp_next");
        icache_read = 1; icache_address = 32'h0000_0100;
        push(ID_IC, 1'b0, 32'h0000_0100, '0);
        serve("idle_ic", d2);

        check("sb_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
